// File: rtl/aes256_key_schedule_if.sv
// Key-load handshake, status and round-key read port of the AES key schedule.
// The key_128 select exists only when KEYSCHED_AES128_EN is defined.
interface aes256_key_schedule_if;
  logic         key_valid;
  logic         key_ready;
  logic [255:0] key;
`ifdef KEYSCHED_AES128_EN
  logic         key_128;
`endif
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  modport master (
`ifdef KEYSCHED_AES128_EN
    output key_128,
`endif
    output key_valid, key, rd_round,
    input  key_ready, busy, keys_valid, rd_key
  );

  modport slave (
`ifdef KEYSCHED_AES128_EN
    input  key_128,
`endif
    input  key_valid, key, rd_round,
    output key_ready, busy, keys_valid, rd_key
  );
endinterface

// File: rtl/aes256_key_schedule.sv
// Iterative AES-256 key expansion, one 32-bit word per cycle, with a combinational round-key read.
// Defining KEYSCHED_AES128_EN adds a per-key AES-128 mode selected by key_128.
module aes256_key_schedule (
  input  logic                 clk,
  input  logic                 reset,
  aes256_key_schedule_if.slave bus
);

  localparam logic [2047:0] SboxTab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bits [2047-8b -: 8], i.e. index {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTab[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    unique case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e      state_q;
  logic [31:0] w_q [60];
  logic [5:0]  idx_q;
  logic        keys_valid_q, busy_q, key_ready_q;
  logic        mode128;
  logic        accept;
  logic        last_word;
  logic [5:0]  idx_start;
  logic [31:0] t, prev, rot_sub, temp, word_d;

  assign accept = bus.key_valid && key_ready_q;

`ifdef KEYSCHED_AES128_EN
  logic mode128_q;
  assign mode128   = mode128_q;
  assign idx_start = bus.key_128 ? 6'd4 : 6'd8;
`else
  assign mode128   = 1'b0;
  assign idx_start = 6'd8;
`endif

  assign last_word = mode128 ? (idx_q == 6'd43) : (idx_q == 6'd59);

  always_comb begin
    t       = w_q[idx_q - 6'd1];
    prev    = w_q[idx_q - (mode128 ? 6'd4 : 6'd8)];
    rot_sub = sub_word({t[23:0], t[31:24]});
    temp    = t;
    if (mode128) begin
      if (idx_q[1:0] == 2'd0) temp = rot_sub ^ {rcon(idx_q[5:2]), 24'h0};
    end else if (idx_q[2:0] == 3'd0) begin
      temp = rot_sub ^ {rcon({1'b0, idx_q[5:3]}), 24'h0};
    end else if (idx_q[2:0] == 3'd4) begin
      temp = sub_word(t);
    end
    word_d = prev ^ temp;
  end

  // Word store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept) begin
        for (int i = 0; i < 8; i++) w_q[i] <= bus.key[255 - 32*i -: 32];
      end else if (state_q == StExpand) begin
        w_q[idx_q] <= word_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= 6'd0;
      keys_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      key_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            state_q      <= StExpand;
            idx_q        <= idx_start;
            keys_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            key_ready_q  <= 1'b0;
`ifdef KEYSCHED_AES128_EN
            mode128_q    <= bus.key_128;
`endif
          end
        end
        StExpand: begin
          idx_q <= idx_q + 6'd1;
          if (last_word) begin
            state_q      <= StDone;
            keys_valid_q <= 1'b1;
            busy_q       <= 1'b0;
            key_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.key_ready  = key_ready_q;
  assign bus.busy       = busy_q;
  assign bus.keys_valid = keys_valid_q;

  logic [5:0] base;
  always_comb begin
    base       = {bus.rd_round, 2'b00};
    bus.rd_key = '0;
    if (bus.rd_round <= (mode128 ? 4'd10 : 4'd14)) begin
      bus.rd_key = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
    end
  end

endmodule

// File: tb/tb_aes256_key_schedule.sv
// Self-checking bench for aes256_key_schedule: scoreboard of round keys from an independent
// GF(2^8)-derived reference model plus FIPS-197 known answers and handshake timing.
module tb_aes256_key_schedule;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes256_key_schedule_if bus ();
  aes256_key_schedule dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;

  logic [127:0] exp_q [$];
  logic [31:0]  ref_w [60];
  logic [7:0]   ref_sbox [256];

  localparam logic [255:0] KeyA =
    256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
  localparam logic [255:0] KeyB =
    256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from the multiplicative inverse (a^254) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s, res;
    for (int b = 0; b < 256; b++) begin
      inv = (b == 0) ? 8'h00 : 8'h01;
      if (b != 0) for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(b));
      s   = inv;
      res = inv ^ 8'h63;
      for (int k = 0; k < 4; k++) begin
        s   = {s[6:0], s[7]};
        res = res ^ s;
      end
      ref_sbox[b] = res;
    end
  endtask

  function automatic logic [31:0] ref_sub_word(input logic [31:0] w);
    return {ref_sbox[w[31:24]], ref_sbox[w[23:16]], ref_sbox[w[15:8]], ref_sbox[w[7:0]]};
  endfunction

  task automatic ref_expand(input logic [255:0] k, input bit m128);
    int nk    = m128 ? 4 : 8;
    int total = m128 ? 44 : 60;
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < nk; i++) ref_w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = ref_w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int j = 1; j < i / nk; j++) rc = xtime(rc);
        t = ref_sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk == 8 && i % 8 == 4) begin
        t = ref_sub_word(t);
      end
      ref_w[i] = ref_w[i-nk] ^ t;
    end
  endtask

  task automatic push_schedule(input bit m128);
    int maxr = m128 ? 10 : 14;
    for (int r = 0; r < 16; r++) begin
      if (r > maxr) exp_q.push_back('0);
      else exp_q.push_back({ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]});
    end
  endtask

  task automatic sweep();
    logic [127:0] exp;
    for (int r = 0; r < 16; r++) begin
      bus.rd_round = 4'(r);
      #1;
      if (exp_q.size() == 0) begin
        check($sformatf("sb_empty_rk%0d", r), bus.rd_key, ~bus.rd_key);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("rk%0d", r), bus.rd_key, exp);
      end
    end
  endtask

  task automatic read_round(input int r, output logic [127:0] v);
    bus.rd_round = 4'(r);
    #1;
    v = bus.rd_key;
  endtask

  // Offers key k; optionally pulses a different key mid-expansion or resets at abort_at.
  task automatic run_key(input logic [255:0] k, input bit m128, input int glitch_at,
                         input int abort_at);
    int lat = 0;
    int busy_n = 0;
    int ready_n = 0;
    bit done = 1'b0;
    ref_expand(k, m128);
    push_schedule(m128);
    bus.key = k;
`ifdef KEYSCHED_AES128_EN
    bus.key_128 = m128;
`endif
    bus.key_valid = 1'b1;
    while (!done && lat < 200) begin
      tick();
      lat++;
      bus.key_valid = (lat == glitch_at);
      bus.key       = (lat == glitch_at) ? ~k : k;
`ifdef KEYSCHED_AES128_EN
      bus.key_128   = (lat == glitch_at) ? !m128 : m128;
`endif
      if (lat == 1) check("kv_low_after_accept", 128'(bus.keys_valid), 128'(0));
      if (bus.keys_valid) begin
        done = 1'b1;
      end else begin
        busy_n  += int'(bus.busy);
        ready_n += int'(bus.key_ready);
      end
      if (lat == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_kv", 128'(bus.keys_valid), 128'(0));
        check("abort_ready", 128'(bus.key_ready), 128'(1));
        check("abort_busy", 128'(bus.busy), 128'(0));
        exp_q.delete();
        return;
      end
    end
    check("kv_timeout", 128'(done), 128'(1));
    check("latency", 128'(lat), 128'(m128 ? 41 : 53));
    check("busy_cycles", 128'(busy_n), 128'(m128 ? 40 : 52));
    check("ready_during_expand", 128'(ready_n), 128'(0));
  endtask

  logic [127:0] v;

  initial begin
    build_sbox();
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.key       = '0;
    bus.rd_round  = 4'd0;
`ifdef KEYSCHED_AES128_EN
    bus.key_128   = 1'b0;
`endif
    repeat (3) tick();
    check("rst_ready", 128'(bus.key_ready), 128'(1));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_kv", 128'(bus.keys_valid), 128'(0));
    reset = 1'b0;
    tick();

    // FIPS-197 A.3 key with known answers.
    run_key(KeyA, 1'b0, 0, 0);
    sweep();
    read_round(2, v);
    check("w8_w9", 128'(v[127:64]), 128'(64'h9ba35411_8e6925af));
    read_round(14, v);
    check("kat_rk14", v, 128'hfe4890d1_e6188d0b_046df344_706c631e);
    read_round(0, v);
    check("kat_rk0", v, 128'h603deb10_15ca71be_2b73aef0_857d7781);
    read_round(15, v);
    check("kat_rk15_zero", v, 128'h0);

    // A different key pulsed mid-expansion must be ignored.
    run_key(KeyA, 1'b0, 10, 0);
    sweep();

    // Reset coinciding with key_valid wins.
    bus.key = KeyB;
    bus.key_valid = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.key_valid = 1'b0;
    tick();
    check("rst_vs_valid_busy", 128'(bus.busy), 128'(0));
    check("rst_vs_valid_ready", 128'(bus.key_ready), 128'(1));

    // Reset in EXPAND cycle 20, then a full re-offer.
    run_key(KeyA, 1'b0, 0, 20);
    run_key(KeyA, 1'b0, 0, 0);
    sweep();

    // Back-to-back: key B offered in the first DONE cycle.
    run_key(KeyA, 1'b0, 0, 0);
    exp_q.delete();
    run_key(KeyB, 1'b0, 0, 0);
    sweep();

`ifdef KEYSCHED_AES128_EN
    run_key(256'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 1'b1, 15, 0);
    sweep();
    read_round(1, v);
    check("kat128_w4", 128'(v[127:96]), 128'(32'ha0fafe17));
    read_round(10, v);
    check("kat128_rk10", v, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    read_round(11, v);
    check("kat128_rk11_zero", v, 128'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
